ip_packet_rx: RTL

IP_PACKET_RX -- requirements
Module: ip_packet_rx

---
 rtl/ip_packet_pkg.sv | 54 +++++
 rtl/ip_packet_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ip_packet_pkg.sv
// Shared definitions for the accelerator's Ethernet/IPv4 frame format.
// Used by both the receiver and the transmitter.
package ip_packet_pkg;

  localparam int MAC_ADDR_W = 48;
  localparam int IP_ADDR_W  = 32;
  localparam int BYTE_W     = 8;
  localparam int MSG_W      = 10;
  localparam int CNT_W      = 6;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int IP_HDR_BYTES    = 20;
  localparam int USER_DATA_BYTES = 2;
  localparam int FRAME_BYTES     = ETH_HDR_BYTES + IP_HDR_BYTES + USER_DATA_BYTES;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

  // Byte offsets within a frame, sized to the byte counter.
  localparam logic [CNT_W-1:0] DST_MAC_OFS   = CNT_W'(0);
  localparam logic [CNT_W-1:0] SRC_MAC_OFS   = CNT_W'(6);
  localparam logic [CNT_W-1:0] ETHERTYPE_OFS = CNT_W'(12);
  localparam logic [CNT_W-1:0] VER_IHL_OFS   = CNT_W'(ETH_HDR_BYTES);
  localparam logic [CNT_W-1:0] SRC_IP_OFS    = CNT_W'(26);
  localparam logic [CNT_W-1:0] DST_IP_OFS    = CNT_W'(30);
  localparam logic [CNT_W-1:0] PAYLOAD_OFS   = CNT_W'(ETH_HDR_BYTES + IP_HDR_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE_IDX = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV_ETH_HDR,
    RECV_IP_HDR,
    RECV_USER_DATA,
    HOLD_RESULT,
    DROP
  } rx_state_e;

  // Byte k (0 = most significant) of a big-endian MAC address.
  function automatic logic [BYTE_W-1:0] mac_byte(input logic [MAC_ADDR_W-1:0] mac,
                                                 input logic [2:0] k);
    logic [MAC_ADDR_W-1:0] sh;
    sh = mac << (BYTE_W * k);
    return sh[MAC_ADDR_W-1 -: BYTE_W];
  endfunction

  // Byte k (0 = most significant) of a big-endian IPv4 address.
  function automatic logic [BYTE_W-1:0] ip_byte(input logic [IP_ADDR_W-1:0] ip,
                                                input logic [1:0] k);
    logic [IP_ADDR_W-1:0] sh;
    sh = ip << (BYTE_W * k);
    return sh[IP_ADDR_W-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/ip_packet_rx.sv
// Receives a fixed 36-byte Ethernet/IPv4 frame addressed to the accelerator
// and presents its source addresses and 10-bit payload until consumed.
module ip_packet_rx
  import ip_packet_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [IP_ADDR_W-1:0]  accelerator_ip_address,
  input  logic [MAC_ADDR_W-1:0] accelerator_mac_address,
  input  logic [BYTE_W-1:0]     mac_data_in,
  input  logic                  mac_data_valid,
  input  logic                  mac_data_first,
  input  logic                  mac_data_last,
  output logic                  mac_data_ready,
  output logic [IP_ADDR_W-1:0]  sender_ip_address,
  output logic [MAC_ADDR_W-1:0] sender_mac_address,
  output logic [MSG_W-1:0]      sender_message,
  output logic                  message_valid,
  input  logic                  message_ready,
  output logic                  rx_error
);

  rx_state_e r_state, w_next_state;
  logic [CNT_W-1:0]      r_cnt, w_next_cnt;
  logic [CNT_W-1:0]      w_idx, w_idx_inc, w_ip_off;
  logic                  w_xfer, w_process, w_err;
  logic                  w_chk, w_mismatch;
  logic [BYTE_W-1:0]     w_exp;
  logic                  r_rx_error;
  logic [MAC_ADDR_W-1:0] r_src_mac;
  logic [IP_ADDR_W-1:0]  r_src_ip;
  logic [MSG_W-1:0]      r_msg;

  assign mac_data_ready = (r_state != HOLD_RESULT);
  assign w_xfer         = mac_data_valid & mac_data_ready;

  // A first-flagged byte always restarts the frame at index 0.
  assign w_idx     = (r_state == IDLE || mac_data_first) ? DST_MAC_OFS : r_cnt;
  assign w_idx_inc = w_idx + CNT_W'(1);
  assign w_ip_off  = w_idx - DST_IP_OFS;

  // Expected value for the bytes that decide whether the frame is ours.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_chk = 1'b0;
    w_exp = '0;
    if (w_idx < SRC_MAC_OFS) begin
      w_chk = 1'b1;
      w_exp = mac_byte(accelerator_mac_address, w_idx[2:0]);
    end else if (w_idx == ETHERTYPE_OFS) begin
      w_chk = 1'b1;
      w_exp = ETHERTYPE_IPV4[15:8];
    end else if (w_idx == ETHERTYPE_OFS + CNT_W'(1)) begin
      w_chk = 1'b1;
      w_exp = ETHERTYPE_IPV4[7:0];
    end else if (w_idx == VER_IHL_OFS) begin
      w_chk = 1'b1;
      w_exp = IPV4_VER_IHL;
    end else if (w_idx >= DST_IP_OFS && w_idx < PAYLOAD_OFS) begin
      w_chk = 1'b1;
      w_exp = ip_byte(accelerator_ip_address, w_ip_off[1:0]);
    end
  end

  assign w_mismatch = w_chk && (mac_data_in != w_exp);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_process    = 1'b0;
    w_err        = 1'b0;

    case (r_state)
      IDLE: w_process = w_xfer & mac_data_first;
      RECV_ETH_HDR, RECV_IP_HDR, RECV_USER_DATA: begin
        w_process = w_xfer;
        w_err     = w_xfer & mac_data_first;
      end
      DROP: begin
        if (w_xfer && mac_data_last) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      end
      HOLD_RESULT: begin
        if (message_ready) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase

    if (w_process) begin
      if (mac_data_last && w_idx != LAST_BYTE_IDX) begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
        w_err        = 1'b1;
      end else if (w_idx == LAST_BYTE_IDX) begin
        w_next_cnt = w_idx;
        if (mac_data_last) begin
          w_next_state = HOLD_RESULT;
        end else begin
          w_next_state = DROP;
          w_err        = 1'b1;
        end
      end else if (w_mismatch) begin
        w_next_state = DROP;
        w_next_cnt   = '0;
      end else begin
        w_next_cnt = w_idx_inc;
        if (w_idx_inc < VER_IHL_OFS) begin
          w_next_state = RECV_ETH_HDR;
        end else if (w_idx_inc < PAYLOAD_OFS) begin
          w_next_state = RECV_IP_HDR;
        end else begin
          w_next_state = RECV_USER_DATA;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rx_error <= 1'b0;
      r_src_mac  <= '0;
      r_src_ip   <= '0;
      r_msg      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all update from pre-edge values.
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_rx_error <= w_err;
      // Source fields shift in byte by byte; a full frame rewrites every byte.
      if (w_process) begin
        if (w_idx >= SRC_MAC_OFS && w_idx < ETHERTYPE_OFS) begin
          r_src_mac <= {r_src_mac[MAC_ADDR_W-BYTE_W-1:0], mac_data_in};
        end
        if (w_idx >= SRC_IP_OFS && w_idx < DST_IP_OFS) begin
          r_src_ip <= {r_src_ip[IP_ADDR_W-BYTE_W-1:0], mac_data_in};
        end
        if (w_idx == PAYLOAD_OFS) begin
          r_msg[MSG_W-1:BYTE_W] <= mac_data_in[MSG_W-BYTE_W-1:0];
        end
        if (w_idx == LAST_BYTE_IDX) begin
          r_msg[BYTE_W-1:0] <= mac_data_in;
        end
      end
    end
  end

  assign message_valid      = (r_state == HOLD_RESULT);
  assign rx_error           = r_rx_error;
  assign sender_mac_address = r_src_mac;
  assign sender_ip_address  = r_src_ip;
  assign sender_message     = r_msg;

endmodule
